// File: rtl/gate_vec_checker.sv
// gate_vec_checker: self-running stimulus/checker around a basic gates block
//   (t0=a&b, t1=a|b, t2=~c). Walks all eight {a,b,c} vectors, holds each for
//   HOLD_CYCLES clocks, samples t0..t2 for one CHECK clock, counts mismatches.
// Parameters:
//   HOLD_CYCLES  clocks each vector is held before sampling (>=1)
//   CNT_W        width of the saturating mismatch counter (>=2)
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        begin a run; accepted only in IDLE or DONE
//   t0, t1, t2   gates block outputs under check
//   a, b, c      stimulus to the gates block, {a,b,c} == vec_idx
//   busy         high while settling or checking
//   done         high once all vectors are checked, until next start/reset
//   pass         valid with done: 1 iff no mismatch was seen
//   err_cnt      mismatch count, saturating at all ones
//   vec_idx      vector currently applied
// Optional feature (macro GVC_FIRST_FAIL_EN):
//   first_fail_vld/vec/obs capture the first mismatching vector of a run and
//   the observed {t0,t1,t2}; frozen until reset or an accepted start.
module gate_vec_checker #(
    parameter int HOLD_CYCLES = 20,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef GVC_FIRST_FAIL_EN
    output logic             first_fail_vld,
    output logic [2:0]       first_fail_vec,
    output logic [2:0]       first_fail_obs,
`endif
    input  logic             t0,
    input  logic             t1,
    input  logic             t2,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       vec_idx
);
    // Counter only needs to hold HOLD_CYCLES-1.
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] RELOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t           state;
    logic [HW-1:0]    cnt;
    logic [2:0]       obs;
    logic [2:0]       exp_v;
    logic             miss;
    logic [CNT_W-1:0] err_nxt;

    assign obs     = {t0, t1, t2};
    assign exp_v   = {a & b, a | b, ~c};
    assign miss    = obs != exp_v;
    // Count including the vector under check, so pass can be decided in the
    // same clock that the last vector is checked.
    assign err_nxt = (miss && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            {a, b, c} <= 3'b000;
            vec_idx   <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
`ifdef GVC_FIRST_FAIL_EN
            first_fail_vld <= 1'b0;
            first_fail_vec <= 3'd0;
            first_fail_obs <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= SETTLE;
                        cnt       <= RELOAD;
                        {a, b, c} <= 3'b000;
                        vec_idx   <= 3'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_cnt   <= '0;
`ifdef GVC_FIRST_FAIL_EN
                        first_fail_vld <= 1'b0;
                        first_fail_vec <= 3'd0;
                        first_fail_obs <= 3'd0;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           state <= CHECK;
                end
                CHECK: begin
                    err_cnt <= err_nxt;
`ifdef GVC_FIRST_FAIL_EN
                    if (miss && !first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_vec <= vec_idx;
                        first_fail_obs <= obs;
                    end
`endif
                    if (vec_idx == 3'd7) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= err_nxt == '0;
                    end else begin
                        state     <= SETTLE;
                        cnt       <= RELOAD;
                        vec_idx   <= vec_idx + 3'd1;
                        {a, b, c} <= vec_idx + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_vec_checker.sv
// tb_gate_vec_checker: randomized fault-injection bench for gate_vec_checker
module tb_gate_vec_checker;
    localparam int HOLD = 20;
    localparam int CW   = 3;
    localparam int SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          a, b, c, t0, t1, t2, busy, done, pass;
    logic [CW-1:0] err_cnt;
    logic [2:0]    vec_idx;
`ifdef GVC_FIRST_FAIL_EN
    logic          ffv;
    logic [2:0]    ffvec, ffobs;
`endif
    // Per-vector XOR fault applied on top of an ideal gates block.
    logic [2:0]    fmask [8];
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] ideal(input int v);
        int av = (v >> 2) & 1, bv = (v >> 1) & 1, cv = v & 1;
        return {av * bv == 1, av + bv > 0, cv == 0};
    endfunction

    assign {t0, t1, t2} = ideal(int'({a, b, c})) ^ fmask[{a, b, c}];

    gate_vec_checker #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef GVC_FIRST_FAIL_EN
        .first_fail_vld(ffv), .first_fail_vec(ffvec), .first_fail_obs(ffobs),
`endif
        .t0(t0), .t1(t1), .t2(t2), .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .vec_idx(vec_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_err();
        int n = 0;
        for (int v = 0; v < 8; v++) if (fmask[v] != 3'b000) n++;
        return n > SAT ? SAT : n;
    endfunction

    task automatic run(input bit hold_start);
        int n = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        check("start_done", done, 0);
        check("start_err", err_cnt, 0);
        check("start_vec", vec_idx, 0);
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (!done) begin
                check("busy", busy, 1);
                check("abc", {a, b, c}, vec_idx);
            end
        end
        check("latency", n, 8 * (HOLD + 1));
        check("busy_end", busy, 0);
        check("err_cnt", err_cnt, exp_err());
        check("pass", pass, exp_err() == 0);
        check("vec_end", {a, b, c, vec_idx}, 6'b111111);
`ifdef GVC_FIRST_FAIL_EN
        begin
            int fv = -1;
            for (int v = 7; v >= 0; v--) if (fmask[v] != 3'b000) fv = v;
            check("ff_vld", ffv, fv >= 0);
            if (fv >= 0) begin
                check("ff_vec", ffvec, fv);
                check("ff_obs", ffobs, ideal(fv) ^ fmask[fv]);
            end
        end
`endif
    endtask

    task automatic check_reset_vals();
        check("rst_outs", {a, b, c, busy, done, pass, vec_idx}, 0);
        check("rst_err", err_cnt, 0);
`ifdef GVC_FIRST_FAIL_EN
        check("rst_ff", {ffv, ffvec, ffobs}, 0);
`endif
    endtask

    task automatic set_mask(input int mode);
        for (int v = 0; v < 8; v++)
            case (mode)
                0: fmask[v] = 3'b000;
                1: fmask[v] = v >= 2 ? 3'b010 : 3'b000;   // t1 stuck 0
                2: fmask[v] = v <= 5 ? 3'b100 : 3'b000;   // t0 stuck 1
                3: fmask[v] = 3'b111;                     // every output wrong
                default: fmask[v] = $urandom_range(0, 2) == 0 ? 3'($urandom_range(1, 7)) : 3'b000;
            endcase
    endtask

    initial begin
        set_mask(0);
        #12;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_stays", {busy, done}, 0);

        for (int m = 0; m < 4; m++) begin
            set_mask(m);
            run(0);
        end
        for (int r = 0; r < 8; r++) begin
            set_mask(4);
            run(0);
        end

        // start held through a run: no restart while busy, restart after done
        set_mask(4);
        fmask[5] = 3'b001;
        run(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_done", done, 0);
        check("restart_err", err_cnt, 0);
        check("restart_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        // reset in the middle of vector 3 settling, then a clean run
        set_mask(1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3 * (HOLD + 1) + 5) @(posedge clk);
        #1;
        check("mid_vec", vec_idx, 3);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_mask(0);
        run(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
